// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_fetch_pkg
//  Purpose  : Shared types and constants for the RV32I instruction-fetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_fetch_pkg;

    // Default address / PC width
    localparam int XLEN_DEF = 32;

    // addi x0, x0, 0 : shown on if_inst whenever nothing valid is presented
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // One fetched instruction together with the PC it was fetched from
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         inst;
    } fetch_entry_t;

endpackage : rv_fetch_pkg
`default_nettype wire

// File: rtl/rv_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous FIFO of fetch entries with push/pop/flush and an
//             occupancy count. Pointers are log2(DEPTH) bits and wrap freely.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,      // asynchronous, active-low
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q,  count_d;
    logic           do_push;
    logic           do_pop;

    // Pointer and count update; flush wins over everything else
    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && !flush && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Control state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while count is zero so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/rv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : rv_fetch_unit
//  Purpose  : In-order instruction fetch with a DEPTH-entry return queue,
//             credit-based request throttling and redirect/squash handling.
//             Optional feature macro: FETCHQ_BYPASS_EN (response -> decode in
//             the same cycle when the queue is empty).
//  Revision : 1.0 - initial release
// ============================================================================
module rv_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,          // asynchronous, active-low
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [31:0]            imem_rsp_data,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [XLEN-1:0]        if_pc,
    output logic [31:0]            if_inst,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;   // occupancy width
    // Killed requests can overlap a fresh window of DEPTH live ones, so the
    // outstanding counter must reach 2*DEPTH.
    localparam int OW = $clog2(DEPTH) + 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   kill_q, kill_d;

    logic [OW-1:0]   live_outstanding;
    logic [OW:0]     used_slots;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_legal;
    logic            rsp_keep;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_aligned;
    entry_t          push_entry;
    entry_t          head;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit: a request is allowed only if its response is guaranteed a slot
    always_comb begin
        live_outstanding = outstanding_q - kill_q;
        used_slots       = (OW+1)'(fifo_count) + (OW+1)'(live_outstanding);
        credit_ok        = used_slots < (OW+1)'(DEPTH);
    end

    assign imem_req_valid = reset && credit_ok && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is discarded outright
    assign rsp_legal = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep  = rsp_legal && (kill_q == '0) && !redirect_valid;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = rsp_keep && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word accepted by decode never enters the queue
    assign push            = rsp_keep && !(bypass && if_ready);
    assign pop             = !fifo_empty && if_ready && !redirect_valid;
    assign push_entry.pc   = rsp_pc_q;
    assign push_entry.inst = imem_rsp_data;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Decode-side view: queue head first, otherwise the bypassed response
    always_comb begin
        if_valid = !fifo_empty || bypass;
        if (!fifo_empty) begin
            if_pc   = head.pc;
            if_inst = head.inst;
        end else begin
            if_pc   = rsp_pc_q;
            if_inst = bypass ? imem_rsp_data : INST_NOP;
        end
    end

    assign occupancy = fifo_count;

    // Next-state for PCs and counters; redirect overrides the normal updates
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        kill_d        = kill_q;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_legal);
        if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (rsp_keep) rsp_pc_d = rsp_pc_q + XLEN'(4);
        if (rsp_legal && (kill_q != '0)) kill_d = kill_q - OW'(1);
        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            kill_d     = outstanding_q - OW'(rsp_legal);
        end
    end

    // PC and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    // Memory must never return more words than were requested
    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!reset)
        !(imem_rsp_valid && (outstanding_q == '0)));

endmodule : rv_fetch_unit
`default_nettype wire
